prime_pair_search: RTL and testbench

- Key-generation front end. Forms odd, top-bit-set candidates from the free-running random source and drives them one at a time into the Miller-Rabin prime tester.
- Consumes the tester's verdict and steps the candidate by 2 on each failure.
- Returns two distinct primes p and q to the downstream RSA modulus/exponent stage.

---
 rtl/prime_pair_search.sv | 187 ++++++++++++++++++
 tb/tb_prime_pair_search.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_pair_search.sv
// prime_pair_search: draws odd, top-bit-set candidates from the random source,
// feeds them one at a time to the Miller-Rabin tester and collects two
// distinct primes p and q for the RSA modulus stage.
module prime_pair_search #(
  parameter int mbit         = 63,
  parameter int pbit         = 31,
  parameter int max_tries    = 1024,
  parameter int busy_timeout = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [mbit:0]   seed,
  output logic [mbit:0]   test_n,
  input  logic            test_busy,
  input  logic            test_isprime,
  output logic [pbit:0]   p,
  output logic [pbit:0]   q,
  output logic            busy,
  output logic            done,
  output logic            fail
);

  localparam int TW  = $clog2(max_tries + 1);
  localparam int TMW = (busy_timeout > 1) ? $clog2(busy_timeout) : 1;
  localparam logic [TW-1:0]  MAX_T  = TW'(max_tries);
  localparam logic [TMW-1:0] T_LAST = TMW'(busy_timeout - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT_RISE, WAIT_FALL, EVAL, FINISH
  } state_t;

  state_t           state, state_d;
  logic             target, target_d;     // 0: searching p, 1: searching q
  logic [pbit:0]    cand, cand_d;
  logic [mbit:0]    test_n_d;
  logic [TW-1:0]    tries, tries_d;
  logic [TMW-1:0]   timer, timer_d;
  logic             retry, retry_d;       // next ISSUE is a retrigger, not a new try
  logic             verdict, verdict_d;
  logic [pbit:0]    p_d, q_d;
  logic             busy_d, done_d, fail_d;

  logic [pbit+1:0]  cand_inc;
  logic [pbit:0]    seed_cand;
  logic             seed_unused;

  assign cand_inc    = {1'b0, cand} + (pbit+2)'(2);
  assign seed_cand   = {1'b1, seed[pbit-1:1], 1'b1};
  assign seed_unused = ^{seed[mbit:pbit], seed[0]};

  // State and datapath register, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      target  <= 1'b0;
      cand    <= '0;
      test_n  <= '0;
      tries   <= '0;
      timer   <= '0;
      retry   <= 1'b0;
      verdict <= 1'b0;
      p       <= '0;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state   <= state_d;
      target  <= target_d;
      cand    <= cand_d;
      test_n  <= test_n_d;
      tries   <= tries_d;
      timer   <= timer_d;
      retry   <= retry_d;
      verdict <= verdict_d;
      p       <= p_d;
      q       <= q_d;
      busy    <= busy_d;
      done    <= done_d;
      fail    <= fail_d;
    end
  end

  // Next-state and datapath update for the search sequence
  always_comb begin
    state_d   = state;
    target_d  = target;
    cand_d    = cand;
    test_n_d  = test_n;
    tries_d   = tries;
    timer_d   = timer;
    retry_d   = retry;
    verdict_d = verdict;
    p_d       = p;
    q_d       = q;
    busy_d    = busy;
    done_d    = done;
    fail_d    = fail;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          target_d = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          fail_d   = 1'b0;
          tries_d  = '0;
          retry_d  = 1'b0;
          // results cleared on accept so an unfound prime reads back as 0
          p_d      = '0;
          q_d      = '0;
        end
      end

      LOAD: begin
        cand_d  = seed_cand;
        state_d = ISSUE;
      end

      ISSUE: begin
        if (target && (cand == p)) begin
          // re-testing p would leave test_n unchanged and never restart the tester
          cand_d = cand_inc[pbit:0];
        end else begin
          test_n_d = {{(mbit-pbit){1'b0}}, cand};
          if (!retry) tries_d = tries + 1'b1;
          retry_d  = 1'b0;
          timer_d  = '0;
          state_d  = WAIT_RISE;
        end
      end

      WAIT_RISE: begin
        if (test_busy) begin
          state_d = WAIT_FALL;
        end else if (timer == T_LAST) begin
          // drop test_n to 0 for one cycle so the same candidate re-triggers
          test_n_d = '0;
          retry_d  = 1'b1;
          state_d  = ISSUE;
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      WAIT_FALL: begin
        if (!test_busy) begin
          verdict_d = test_isprime;
          state_d   = EVAL;
        end
      end

      EVAL: begin
        if (verdict) begin
          if (!target) begin
            p_d      = cand;
            target_d = 1'b1;
            tries_d  = '0;
            state_d  = LOAD;
          end else begin
            q_d     = cand;
            state_d = FINISH;
          end
        end else if (tries == MAX_T) begin
          fail_d  = 1'b1;
          state_d = FINISH;
        end else if (cand_inc[pbit+1]) begin
          state_d = LOAD;
        end else begin
          cand_d  = cand_inc[pbit:0];
          state_d = ISSUE;
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prime_pair_search.sv
// Bench for prime_pair_search: behavioural tester plus an arithmetic search
// model that predicts the distinct candidate stream and final p/q/fail.
module tb_prime_pair_search;
  localparam int MB = 15;
  localparam int PB = 7;
  localparam int MT = 8;
  localparam int BT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [MB:0]   seed = '0;
  logic [MB:0]   test_n;
  logic          test_busy = 1'b0;
  logic          test_isprime = 1'b0;
  logic [PB:0]   p, q;
  logic          busy, done, fail;

  prime_pair_search #(.mbit(MB), .pbit(PB), .max_tries(MT), .busy_timeout(BT)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .test_n(test_n),
    .test_busy(test_busy), .test_isprime(test_isprime),
    .p(p), .q(q), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- behavioural tester ----------------
  typedef enum int {T_REAL, T_COMP, T_NEVER} tmode_t;
  tmode_t      tmode = T_REAL;
  int          t_phase = 0;
  int          t_cnt = 0;
  logic [MB:0] t_last = '0;
  logic [MB:0] t_cur = '0;

  always @(negedge clk) begin
    if (!rst) begin
      t_phase   = 0;
      t_cnt     = 0;
      t_last    = '0;
      test_busy = 1'b0;
    end else begin
      bit changed;
      changed = (test_n != t_last);
      t_last  = test_n;
      case (t_phase)
        0: if (changed && test_n != 0 && tmode != T_NEVER) begin
             t_cur = test_n; t_phase = 1; t_cnt = 1;
           end
        1: begin
             t_cnt++;
             if (t_cnt >= 2) begin test_busy = 1'b1; t_phase = 2; t_cnt = 0; end
           end
        default: begin
             t_cnt++;
             if (t_cnt >= 3) begin
               test_busy    = 1'b0;
               test_isprime = (tmode == T_REAL) ? is_prime(int'(t_cur)) : 1'b0;
               t_phase      = 0;
             end
           end
      endcase
    end
  end

  // ---------------- search model ----------------
  int exp_tn[$];
  int exp_p, exp_q;
  bit exp_fail;

  task automatic model_run(input int s0, input int s1, input int s2, input bit comp);
    int seeds[3];
    int li, cand, tries;
    bit tq;
    seeds = '{s0, s1, s2};
    exp_tn.delete();
    exp_p = 0; exp_q = 0; exp_fail = 1'b0;
    tries = 0; tq = 1'b0;
    cand = 128 | (seeds[0] & 126) | 1; li = 1;
    for (int k = 0; k < 200; k++) begin
      if (tq && cand == exp_p) cand = (cand + 2) % 256;
      exp_tn.push_back(cand);
      tries++;
      if (!comp && is_prime(cand)) begin
        if (!tq) begin
          exp_p = cand; tq = 1'b1; tries = 0;
          cand = 128 | (seeds[li] & 126) | 1; if (li < 2) li++;
        end else begin
          exp_q = cand; break;
        end
      end else if (tries == MT) begin
        exp_fail = 1'b1; break;
      end else if (cand + 2 > 255) begin
        cand = 128 | (seeds[li] & 126) | 1; if (li < 2) li++;
      end else begin
        cand = cand + 2;
      end
    end
  endtask

  // ---------------- compare process ----------------
  bit          cmp_en = 1'b0;
  logic [MB:0] last_nz = '0;
  int          seen_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en && rst) begin
      check("test_n_upper_zero", 64'(test_n[MB:PB+1]), 64'd0);
      if (test_n != 0 && test_n != last_nz) begin
        last_nz = test_n;
        seen_cnt++;
        if (exp_tn.size() == 0) check("test_n_unexpected", 64'(test_n), 64'd0);
        else check("test_n_seq", 64'(test_n), 64'(exp_tn.pop_front()));
      end
      if (done) check("busy_low_with_done", 64'(busy), 64'd0);
    end
  end

  // ---------------- helpers ----------------
  task automatic setup_run(input int s0, input int s1, input int s2, input bit comp);
    model_run(s0, s1, s2, comp);
    seed     = MB'(s0);
    last_nz  = test_n;
    seen_cnt = 0;
    cmp_en   = 1'b1;
  endtask

  task automatic pulse_start(input bit hold);
    @(negedge clk) start = 1'b1;
    @(negedge clk) if (!hold) start = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_done_low", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int s0, input int s1);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (int'(test_n) == (128 | (s0 & 126) | 1)) seed = MB'(s1);
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    if (!got) $display("FAIL %s_timeout: got done=0 expected done=1", tag);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_p"}, 64'(p), 64'(exp_p));
    check({tag, "_q"}, 64'(q), 64'(exp_q));
    check({tag, "_fail"}, 64'(fail), 64'(exp_fail));
    check({tag, "_all_seen"}, 64'(exp_tn.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got;
    #1;
    check("rst_test_n", 64'(test_n), 64'd0);
    check("rst_p", 64'(p), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic pair: 145,147,149 then 145,147,(149 skipped),151
    tmode = T_REAL;
    setup_run(8'h10, 8'h10, 8'h10, 1'b0);
    pulse_start(1'b0);
    wait_done("pair", 8'h10, 8'h10);
    check("pair_p_lit", 64'(p), 64'd149);
    check("pair_q_lit", 64'(q), 64'd151);
    check("pair_seen_lit", 64'(seen_cnt), 64'd6);

    // start held through the whole search, incl. the cycle done rises
    setup_run(8'h10, 8'h10, 8'h10, 1'b0);
    pulse_start(1'b1);
    wait_done("hold", 8'h10, 8'h10);
    repeat (4) @(negedge clk);
    check("hold_done_stays", 64'(done), 64'd1);
    check("hold_busy_stays", 64'(busy), 64'd0);
    check("hold_p_lit", 64'(p), 64'd149);
    check("hold_q_lit", 64'(q), 64'd151);

    // wrap: 255 composite, +2 carries, reseed from 0x46 -> 199
    setup_run(8'hFE, 8'h46, 8'h46, 1'b0);
    pulse_start(1'b0);
    wait_done("wrap", 8'hFE, 8'h46);
    check("wrap_p_lit", 64'(p), 64'd199);
    check("wrap_q_lit", 64'(q), 64'd211);

    // tester never goes busy: retrigger every BT+1 cycles, then all-composite
    tmode = T_NEVER;
    setup_run(8'h10, 8'h10, 8'h10, 1'b1);
    pulse_start(1'b0);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (test_n == MB'(145)) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("retrig_first_issue", 64'(got), 64'd1);
    for (int i = 0; i < 3 * (BT + 1); i++) begin
      check("retrig_pattern", 64'(test_n), (i % (BT + 1) == BT) ? 64'd0 : 64'd145);
      check("retrig_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    #1 tmode = T_COMP;
    wait_done("comp", 8'h10, 8'h10);
    check("comp_fail_lit", 64'(fail), 64'd1);
    check("comp_p_lit", 64'(p), 64'd0);
    check("comp_q_lit", 64'(q), 64'd0);
    check("comp_seen_lit", 64'(seen_cnt), 64'd8);

    // asynchronous reset during the q search's WAIT_FALL
    tmode = T_REAL;
    setup_run(8'h10, 8'h10, 8'h10, 1'b0);
    pulse_start(1'b0);
    got = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (p != 0 && test_busy) begin got = 1'b1; break; end
    end
    check("rst_mid_reached_q", 64'(got), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b0;
    #1;
    check("rst_mid_test_n", 64'(test_n), 64'd0);
    check("rst_mid_p", 64'(p), 64'd0);
    check("rst_mid_q", 64'(q), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_fail", 64'(fail), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    setup_run(8'h10, 8'h10, 8'h10, 1'b0);
    pulse_start(1'b0);
    wait_done("after_rst", 8'h10, 8'h10);
    check("after_rst_p_lit", 64'(p), 64'd149);
    check("after_rst_q_lit", 64'(q), 64'd151);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
